// File: rtl/can_lbm_pkg.sv
// Shared definitions for the legacy SJA1000 bus master: FSM state codes,
// SJA1000 register addresses and small elaboration helpers.
package can_lbm_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_STB  = 2'd2;
   localparam logic [1:0] ST_TURN = 2'd3;

   localparam logic [7:0] REG_MODE    = 8'h00;
   localparam logic [7:0] REG_COMMAND = 8'h01;
   localparam logic [7:0] REG_STATUS  = 8'h02;
   localparam logic [7:0] REG_IR      = 8'h03;
   localparam logic [7:0] REG_BTR0    = 8'h06;
   localparam logic [7:0] REG_BTR1    = 8'h07;
   localparam logic [7:0] REG_CLKDIV  = 8'h1F;

   typedef struct packed {
      logic       we;
      logic [7:0] adr;
      logic [7:0] wdat;
   } acc_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // index width stays >= 1 so a single-requester build still has a pointer
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/can_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last
// winner, so the previous winner has lowest priority.
module can_rr_arbiter
   import can_lbm_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int IW    = 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IW-1:0]    idx,
   output logic             vld
);

   always_comb begin
      int k;
      k   = 0;
      gnt = '0;
      idx = '0;
      vld = 1'b0;
      for (int i = 1; i <= N_REQ; i++) begin
         k = (int'(ptr) + i) % N_REQ;
         if (!vld && req[k]) begin
            vld    = 1'b1;
            gnt[k] = 1'b1;
            idx    = IW'(k);
         end
      end
   end

endmodule

// File: rtl/can_legacy_bus_master.sv
// Shares one SJA1000-style multiplexed bus (cs/ale/rd/wr + 8-bit port) between
// N_REQ requesters; each access is ADDR -> STB -> TURN with fully registered outputs.
module can_legacy_bus_master
   import can_lbm_pkg::*;
#(
   parameter int N_REQ       = 2,
   parameter int ALE_CYCLES  = 1,
   parameter int STB_CYCLES  = 1,
   parameter int TURN_CYCLES = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_in,
   input  logic [N_REQ-1:0]     req_i,
   input  logic [N_REQ-1:0]     we_i,
   input  logic [8*N_REQ-1:0]   adr_i,
   input  logic [8*N_REQ-1:0]   wdat_i,
   output logic [N_REQ-1:0]     ack_o,
   output logic [7:0]           rdat_o,
   output logic                 busy_o,
   output logic                 cs_can_o,
   output logic                 ale_o,
   output logic                 rd_o,
   output logic                 wr_o,
   output logic [7:0]           port_o,
   output logic                 port_oe_o,
   input  logic [7:0]           port_i
);

   localparam int IW = idx_w(N_REQ);
   localparam int CW = $clog2(max3(ALE_CYCLES, STB_CYCLES, TURN_CYCLES) + 1);
   localparam logic [CW-1:0] ALE_LD  = CW'(ALE_CYCLES - 1);
   localparam logic [CW-1:0] STB_LD  = CW'(STB_CYCLES - 1);
   localparam logic [CW-1:0] TURN_LD = CW'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

   logic [1:0]       state, state_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic [IW-1:0]    ptr, idx;
   logic [N_REQ-1:0] gnt, gnt_q, ack_nx;
   logic             vld, take, rd_cap;
   acc_t             acc_q, acc_nx;
   logic [7:0]       adr_a  [N_REQ];
   logic [7:0]       wdat_a [N_REQ];

   for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
      assign adr_a[k]  = adr_i[8*k +: 8];
      assign wdat_a[k] = wdat_i[8*k +: 8];
   end

   can_rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
      .req (req_i),
      .ptr (ptr),
      .gnt (gnt),
      .idx (idx),
      .vld (vld)
   );

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      take     = 1'b0;
      ack_nx   = '0;
      rd_cap   = 1'b0;
      case (state)
         ST_IDLE: if (vld) begin
            take     = 1'b1;
            state_nx = ST_ADDR;
            cnt_nx   = ALE_LD;
         end
         ST_ADDR: if (cnt == '0) begin
            state_nx = ST_STB;
            cnt_nx   = STB_LD;
         end else cnt_nx = cnt - 1'b1;
         ST_STB: if (cnt == '0) begin
            ack_nx = gnt_q;
            rd_cap = !acc_q.we;
            if (TURN_CYCLES > 0) begin
               state_nx = ST_TURN;
               cnt_nx   = TURN_LD;
            end else begin
               state_nx = ST_IDLE;
               cnt_nx   = '0;
            end
         end else cnt_nx = cnt - 1'b1;
         ST_TURN: if (cnt == '0) state_nx = ST_IDLE;
                  else cnt_nx = cnt - 1'b1;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and next capture so every bus pin is a flop.
   logic       cs_nx, ale_nx, rd_nx, wr_nx, oe_nx;
   logic [7:0] port_nx;
   always_comb begin
      acc_nx = acc_q;
      if (take) acc_nx = '{we: we_i[idx], adr: adr_a[idx], wdat: wdat_a[idx]};
      ale_nx  = (state_nx == ST_ADDR);
      cs_nx   = ale_nx || (state_nx == ST_STB);
      wr_nx   = (state_nx == ST_STB) && acc_nx.we;
      rd_nx   = (state_nx == ST_STB) && !acc_nx.we;
      oe_nx   = ale_nx || wr_nx;
      port_nx = ale_nx ? acc_nx.adr : (wr_nx ? acc_nx.wdat : 8'h00);
   end

   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         ptr       <= IW'(N_REQ - 1);
         gnt_q     <= '0;
         acc_q     <= '0;
         ack_o     <= '0;
         rdat_o    <= 8'h00;
         busy_o    <= 1'b0;
         cs_can_o  <= 1'b0;
         ale_o     <= 1'b0;
         rd_o      <= 1'b0;
         wr_o      <= 1'b0;
         port_o    <= 8'h00;
         port_oe_o <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         acc_q     <= acc_nx;
         if (take) begin
            ptr   <= idx;
            gnt_q <= gnt;
         end
         if (rd_cap) rdat_o <= port_i;
         ack_o     <= ack_nx;
         busy_o    <= (state_nx != ST_IDLE);
         cs_can_o  <= cs_nx;
         ale_o     <= ale_nx;
         rd_o      <= rd_nx;
         wr_o      <= wr_nx;
         port_o    <= port_nx;
         port_oe_o <= oe_nx;
      end
   end

endmodule

// File: tb/tb_can_legacy_bus_master.sv
// Bench: cycle table on a default-parameter master, then a randomized timeline
// model plus register-file slave on a 3-requester ALE=2/STB=3/TURN=2 master.
module tb_can_legacy_bus_master;
   import can_lbm_pkg::*;

   localparam int NB = 3, AL = 2, SB = 3, TN = 2;
   localparam int NRAND = 3000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0, failures = 0;

   // default instance
   logic [1:0]  req_a, we_a, ack_a;
   logic [15:0] adr_a, wdat_a;
   logic [7:0]  rdat_a, port_a, pin_a;
   logic        busy_a, cs_a, ale_a, rd_a, wr_a, oe_a;

   can_legacy_bus_master u_a (
      .clk_i(clk), .rst_in(rst_n), .req_i(req_a), .we_i(we_a), .adr_i(adr_a), .wdat_i(wdat_a),
      .ack_o(ack_a), .rdat_o(rdat_a), .busy_o(busy_a), .cs_can_o(cs_a), .ale_o(ale_a),
      .rd_o(rd_a), .wr_o(wr_a), .port_o(port_a), .port_oe_o(oe_a), .port_i(pin_a));

   // stretched-timing instance
   logic [NB-1:0]   req_b, we_b, ack_b;
   logic [8*NB-1:0] adr_b, wdat_b;
   logic [7:0]      rdat_b, port_b, pin_b;
   logic            busy_b, cs_b, ale_b, rd_b, wr_b, oe_b;

   can_legacy_bus_master #(.N_REQ(NB), .ALE_CYCLES(AL), .STB_CYCLES(SB), .TURN_CYCLES(TN)) u_b (
      .clk_i(clk), .rst_in(rst_n), .req_i(req_b), .we_i(we_b), .adr_i(adr_b), .wdat_i(wdat_b),
      .ack_o(ack_b), .rdat_o(rdat_b), .busy_o(busy_b), .cs_can_o(cs_b), .ale_o(ale_b),
      .rd_o(rd_b), .wr_o(wr_b), .port_o(port_b), .port_oe_o(oe_b), .port_i(pin_b));

   // register-file stand-in for can_top on instance B
   logic [7:0] slv_mem [256];
   logic [7:0] slv_adr;
   logic [7:0] junk;
   assign pin_b = rd_b ? slv_mem[slv_adr] : junk;
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) slv_mem[i] <= 8'(i) ^ 8'h5A;
      end else begin
         if (ale_b) slv_adr <= port_b;
         if (wr_b) slv_mem[slv_adr] <= port_b;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
      end
   endtask

   // ctl = {cs, ale, rd, wr, oe, busy, ack[1], ack[0]}
   typedef struct packed {
      logic [1:0] req, we;
      logic [7:0] a0, a1, d0, d1, pin, ctl, port, rdat;
   } vec_t;
   vec_t tbl [21];

   // transaction-level model of instance B
   logic [7:0]    ref_mem [256];
   logic [NB-1:0] pend, drop;
   int  cyc = 0, g = 0, free_at = 0, ptr_m = NB - 1, t_win = 0;
   bit  have = 0, quiet = 0;
   logic       t_we;
   logic [7:0] t_adr, t_wdat, exp_rdat;

   task automatic step_b();
      int off;
      bit e_ale, e_stb, e_busy, found;
      logic [NB-1:0] e_ack;
      off    = cyc - g;
      e_ale  = have && off >= 1 && off <= AL;
      e_stb  = have && off > AL && off <= AL + SB;
      e_busy = have && off >= 1 && off < AL + SB + 1 + TN;
      e_ack  = (have && off == AL + SB + 1) ? (NB'(1) << t_win) : '0;
      if (e_ack != 0) begin
         if (t_we) ref_mem[t_adr] = t_wdat;
         else exp_rdat = ref_mem[t_adr];
      end
      chk("b_ctl", {cs_b, ale_b, rd_b, wr_b, oe_b, busy_b},
          {e_ale | e_stb, e_ale, e_stb & !t_we, e_stb & t_we, e_ale | (e_stb & t_we), e_busy});
      chk("b_ack", ack_b, e_ack);
      chk("b_rdat", rdat_b, exp_rdat);
      if (oe_b && (e_ale || e_stb)) chk("b_port", port_b, e_ale ? t_adr : t_wdat);
      for (int k = 0; k < NB; k++) begin
         if (ack_b[k]) begin
            pend[k] = !quiet && ($urandom_range(0, 1) == 1);
            drop[k] = 1'b0;
         end else if (!pend[k]) begin
            pend[k] = !quiet && ($urandom_range(0, 3) == 0);
         end else if (have && t_win == k && off >= 1 && off <= AL + SB && $urandom_range(0, 9) == 0) begin
            drop[k] = 1'b1;
         end
         we_b[k]         = 1'($urandom);
         adr_b[8*k +: 8] = 8'($urandom_range(0, 15));
         wdat_b[8*k +: 8] = 8'($urandom);
      end
      req_b = pend & ~drop;
      junk  = 8'($urandom);
      if (cyc >= free_at && req_b != 0) begin
         found = 0;
         for (int i = 1; i <= NB; i++) begin
            if (!found && req_b[(ptr_m + i) % NB]) begin
               found = 1;
               t_win = (ptr_m + i) % NB;
            end
         end
         ptr_m   = t_win;
         g       = cyc;
         t_we    = we_b[t_win];
         t_adr   = adr_b[8*t_win +: 8];
         t_wdat  = wdat_b[8*t_win +: 8];
         have    = 1;
         free_at = cyc + 1 + AL + SB + TN;
      end
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      int bad;
      bit found;
      logic [7:0] act_port, exp_port;
      req_a = '0; we_a = '0; adr_a = '0; wdat_a = '0; pin_a = '0;
      req_b = '0; we_b = '0; adr_b = '0; wdat_b = '0; junk = '0;
      pend = '0; drop = '0; exp_rdat = 8'h00;
      t_we = 1'b0; t_adr = '0; t_wdat = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;

      //                req    we     a0          a1           d0     d1     pin    ctl    port   rdat
      tbl[0]  = '{2'b01, 2'b01, REG_MODE,   REG_CLKDIV, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[1]  = '{2'b01, 2'b01, REG_MODE,   REG_CLKDIV, 8'h01, 8'h00, 8'h00, 8'hCC, 8'h00, 8'h00};
      tbl[2]  = '{2'b01, 2'b01, REG_MODE,   REG_CLKDIV, 8'h01, 8'h00, 8'h00, 8'h9C, 8'h01, 8'h00};
      tbl[3]  = '{2'b10, 2'b01, REG_MODE,   REG_CLKDIV, 8'h01, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00};
      tbl[4]  = '{2'b10, 2'b01, REG_MODE,   REG_CLKDIV, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[5]  = '{2'b10, 2'b01, REG_MODE,   REG_CLKDIV, 8'h01, 8'h00, 8'h00, 8'hCC, 8'h1F, 8'h00};
      tbl[6]  = '{2'b10, 2'b01, REG_MODE,   REG_CLKDIV, 8'h01, 8'h00, 8'h87, 8'hA4, 8'h00, 8'h00};
      tbl[7]  = '{2'b00, 2'b01, REG_MODE,   REG_CLKDIV, 8'h01, 8'h00, 8'h00, 8'h06, 8'h00, 8'h87};
      tbl[8]  = '{2'b11, 2'b01, REG_BTR0,   REG_IR,     8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h87};
      tbl[9]  = '{2'b11, 2'b01, REG_BTR0,   REG_IR,     8'h41, 8'h00, 8'h00, 8'hCC, 8'h06, 8'h87};
      tbl[10] = '{2'b11, 2'b01, REG_BTR0,   REG_IR,     8'h41, 8'h00, 8'h00, 8'h9C, 8'h41, 8'h87};
      tbl[11] = '{2'b11, 2'b01, REG_BTR1,   REG_IR,     8'h56, 8'h00, 8'h00, 8'h05, 8'h00, 8'h87};
      tbl[12] = '{2'b11, 2'b01, REG_BTR1,   REG_IR,     8'h56, 8'h00, 8'h00, 8'h00, 8'h00, 8'h87};
      tbl[13] = '{2'b11, 2'b01, REG_BTR1,   REG_IR,     8'h56, 8'h00, 8'h00, 8'hCC, 8'h03, 8'h87};
      tbl[14] = '{2'b11, 2'b01, REG_BTR1,   REG_IR,     8'h56, 8'h00, 8'h55, 8'hA4, 8'h00, 8'h87};
      tbl[15] = '{2'b01, 2'b01, REG_BTR1,   REG_IR,     8'h56, 8'h00, 8'h00, 8'h06, 8'h00, 8'h55};
      tbl[16] = '{2'b01, 2'b01, REG_BTR1,   REG_IR,     8'h56, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55};
      tbl[17] = '{2'b01, 2'b01, REG_BTR1,   REG_IR,     8'h56, 8'h00, 8'h00, 8'hCC, 8'h07, 8'h55};
      tbl[18] = '{2'b01, 2'b01, REG_BTR1,   REG_IR,     8'h56, 8'h00, 8'h00, 8'h9C, 8'h56, 8'h55};
      tbl[19] = '{2'b00, 2'b01, REG_BTR1,   REG_IR,     8'h56, 8'h00, 8'h00, 8'h05, 8'h00, 8'h55};
      tbl[20] = '{2'b00, 2'b01, REG_BTR1,   REG_IR,     8'h56, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_state", {cs_a, ale_a, rd_a, wr_a, oe_a, busy_a, ack_a, port_a, rdat_a,
                          cs_b, ale_b, rd_b, wr_b, oe_b, busy_b, ack_b, port_b, rdat_b}, '0);

      // cycle table: write MODE, read CLKDIV, contended back-to-back accesses
      for (int r = 0; r < 21; r++) begin
         act_port = oe_a ? port_a : 8'h00;
         exp_port = tbl[r].ctl[3] ? tbl[r].port : 8'h00;
         chk($sformatf("tbl_row%0d", r),
             {cs_a, ale_a, rd_a, wr_a, oe_a, busy_a, ack_a, act_port, rdat_a},
             {tbl[r].ctl, exp_port, tbl[r].rdat});
         req_a  = tbl[r].req;
         we_a   = tbl[r].we;
         adr_a  = {tbl[r].a1, tbl[r].a0};
         wdat_a = {tbl[r].d1, tbl[r].d0};
         pin_a  = tbl[r].pin;
         @(negedge clk);
      end

      // randomized traffic on instance B against the timeline model
      for (int n = 0; n < NRAND; n++) step_b();
      quiet = 1;
      for (int n = 0; n < 4 * (1 + AL + SB + TN); n++) step_b();
      bad = 0;
      for (int a = 0; a < 16; a++) if (slv_mem[a] !== ref_mem[a]) bad++;
      chk("slave_mem", 64'(bad), 64'd0);

      // reset in the middle of a write strobe
      we_b = 3'b001; adr_b = {8'h22, 8'h11, REG_COMMAND}; wdat_b = {8'h00, 8'h00, 8'h77};
      req_b = 3'b001;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         found = wr_b;
      end
      chk("wr_strobe_seen", 64'(found), 64'd1);
      #2 rst_n = 1'b0;
      #1 chk("rst_bus_release", {cs_b, ale_b, rd_b, wr_b, oe_b, busy_b, ack_b, port_b}, '0);
      repeat (2) begin
         @(negedge clk);
         chk("rst_no_ack", ack_b, '0);
      end
      rst_n = 1'b1;
      req_b = 3'b111; we_b = 3'b000; adr_b = {8'h33, 8'h22, 8'h11};
      @(negedge clk);
      chk("regrant_req0_addr", {ale_b, port_b}, {1'b1, 8'h11});
      repeat (AL + SB) @(negedge clk);
      chk("regrant_req0_ack", ack_b, 3'b001);
      req_b = 3'b000;
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
